tdma_scheduler_multi: RTL and testbench
=======================================

// Module: tdma_scheduler_multi
// PURPOSE
//  Multi-channel TDMA scheduler driven by the 96-bit PTP time of day. Repeats a schedule of SLOT_COUNT
//  timeslots from a programmable start time, with a guard interval at the head of each slot.
//  A per-slot channel bitmap table gates CHANNELS independent active outputs.
//  Sits between the PTP clock and per-queue/per-port TX gating logic.
// PARAMETERS
//  INDEX_WIDTH         8          timeslot index width; table depth 2**INDEX_WIDTH
//  CHANNELS            4          number of gated channels (bitmap width)
//  SCHEDULE_START_S/NS 0/0        reset schedule start time (48-bit s / 30-bit ns)
//  SCHEDULE_PERIOD_S/NS 0/1000000 reset schedule period
//  TIMESLOT_PERIOD_S/NS 0/100000  reset timeslot period
//  ACTIVE_PERIOD_S/NS  0/100000   reset active end, measured from slot start
//  GUARD_PERIOD_NS     0          reset guard interval (30 bit, < 1 s), measured from slot start
//  SLOT_COUNT          10         reset number of slots per schedule (1..2**INDEX_WIDTH)
// PORTS
//  clk                      in  1          clock
//  rst                      in  1          reset, asynchronous, active-high
//  input_ts_96              in  96         PTP ToD {s[95:48], ns[45:16], frac[15:0]}
//  input_ts_step            in  1          PTP time step; forces restart with error
//  enable                   in  1          master gate for start/active/channel outputs
//  input_schedule_start(_valid)  in 80+1   {s48,ns32}; write restarts schedule
//  input_schedule_period(_valid) in 80+1   write restarts schedule
//  input_timeslot_period(_valid) in 80+1   takes effect at next slot computation
//  input_active_period(_valid)   in 80+1   takes effect at next slot computation
//  input_guard_period(_valid)    in 30+1   ns only; takes effect at next slot computation
//  input_slot_count(_valid)      in INDEX_WIDTH+1+1 write restarts schedule; 0 treated as 1
//  tbl_wr_en / tbl_wr_addr / tbl_wr_data in 1/INDEX_WIDTH/CHANNELS  channel bitmap table write
//  locked / error           out 1          status
//  schedule_start           out 1          1-cycle pulse at schedule start
//  timeslot_index           out INDEX_WIDTH current slot
//  timeslot_start / timeslot_end out 1     1-cycle pulses
//  timeslot_active          out 1          in active window (after guard, before active end)
//  channel_active           out CHANNELS   timeslot_active & current-slot bitmap
// BEHAVIOUR
//  - All outputs and state reset to 0. Config registers reset to their parameters. Table contents
//    are not reset. Reset asserts restart.
//  - ToD is registered one cycle: s = ts[95:48], ns = ts[45:16]. An event fires when time is
//    strictly greater than its target. Each output updates 1 cycle after the event compare.
//  - Time adds are {s48,ns30}. ns sum is computed alongside sum-1e9; if the 31-bit lookahead does
//    not borrow, take it and carry +1 s. Each add is 2 cycles (compute, select).
//  - FSM: IDLE -> (sched event) SCHED_1 -> SCHED_2 -> SLOT_1..SLOT_6 -> IDLE. A slot event goes
//    IDLE -> SLOT_1..SLOT_6. SCHED: next_sched += sched_period, next_slot = old next_sched.
//    SLOT_1/2: guard_end = next_slot + guard. SLOT_3/4: active_end = next_slot + active.
//    SLOT_5/6: next_slot += slot_period; prefetch table[nxt] into next_mask, where
//    nxt = index+1, or 0 if index+1 == slot_count. Updates complete within 10 cycles;
//    the minimum slot period is 32 clk cycles.
//  - IDLE priority: schedule event > slot event > guard-end event > active-end event.
//    - Schedule event: index=0; schedule_start=timeslot_start=enable&lock_arm; timeslot_end=active.
//    - Slot event, only if index+1 < slot_count: index+1; timeslot_start=enable&locked;
//      timeslot_end=active. Slot events past slot_count are suppressed until the next schedule
//      start.
//    - Guard end with no active end: active=enable&locked. channel_active=mask&{CHANNELS{active}}.
//    - Active end while active: active=0, timeslot_end pulse, channel_active=0.
//  - cur_mask <= next_mask on each slot/schedule event. A table write to the prefetched address
//    after the prefetch takes effect next period. A write and read on the same address returns
//    the old data.
//  - Guard >= active: the slot never goes active. Guard 0: active in the cycle after timeslot_start.
//  - lock_arm sets on any IDLE cycle with no event pending while running. At the next schedule
//    event, locked = lock_arm and error clears if lock_arm. This avoids locking while catching up.
//  - restart (reset, start/period/count write, or input_ts_step), synchronous, overrides the FSM:
//    - next_sched = next_slot = start; index=0; pending pulses are dropped, but timeslot_end
//      pulses if active.
//    - active/channel_active=0; locked=lock_arm=running=0; error=input_ts_step; state=IDLE.
//    - next_mask = table[0], read over 2 cycles; the first schedule event waits for it.
//  - enable low: no start pulses and no activity; index still advances; locked unaffected.
// TESTING
//  1 start=1s, sched=1ms, slot=100us, active=90us, guard=1us, count=4, table={1,2,4,8}; ToD from 0.999s
//    -> slot starts at 1.0,1.1,1.2,1.3 ms-offsets; idx 0..3; nothing beyond idx3; locked at 2nd period.
//  2 Same config, locked -> channel_active=4'h1 from start+1us to +90us, then 4'h2 in slot 1;
//    timeslot_end pulses at +90us.
//  3 input_ts_step mid-slot -> error=1, locked=0, active/channel_active drop next cycle,
//    timeslot_end pulse; error clears when relocked.
//  4 next_slot ns=999_950_000 + slot 100us -> next_slot = s+1, ns=50_000. No ns >= 1e9 ever.
//  5 Rewrite table[2]=4'hF during slot 0 -> appears in slot 2. Write table[1] after the slot-0
//    prefetch -> old bitmap used this period.
//  6 Assert rst async mid-active -> all outputs 0 without a clock edge; schedule restarts from
//    the parameter values.

Source files
------------

// File: rtl/tdma_scheduler_multi.sv
// tdma_scheduler_multi
// Repeating TDMA schedule timed from the 96-bit PTP time of day. A schedule of
// slot_count timeslots starts at schedule_start and repeats every schedule
// period. Each slot opens with a guard interval and ends its active window
// at the active period. A per-slot bitmap table gates CHANNELS outputs.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   input_ts_96                   PTP ToD {s[95:48], ns[45:16], frac[15:0]}
//   input_ts_step                 time step: restart with error
//   enable                        master gate for start pulses and activity
//   input_*_period/_start(_valid) config writes, {s48, ns32} (guard: ns only)
//   input_slot_count(_valid)      slots per schedule, 0 treated as 1
//   tbl_wr_en/addr/data           channel bitmap table write port
//   locked, error                 status
//   schedule_start, timeslot_start, timeslot_end   single-cycle pulses
//   timeslot_index                current slot
//   timeslot_active               inside the active window of the slot
//   channel_active                timeslot_active & current slot bitmap
//
// state   | meaning
// IDLE    | compare ToD against targets, drive outputs
// SCHED_1 | next_slot <= old next_sched, add schedule period
// SCHED_2 | select carry-corrected next_sched
// SLOT_1  | add guard to slot start
// SLOT_2  | select guard_end
// SLOT_3  | add active period to slot start
// SLOT_4  | select active_end
// SLOT_5  | add slot period, issue table read of following slot
// SLOT_6  | select next_slot, capture prefetched bitmap
module tdma_scheduler_multi #(
  parameter int          INDEX_WIDTH        = 8,
  parameter int          CHANNELS           = 4,
  parameter logic [47:0] SCHEDULE_START_S   = 48'd0,
  parameter logic [29:0] SCHEDULE_START_NS  = 30'd0,
  parameter logic [47:0] SCHEDULE_PERIOD_S  = 48'd0,
  parameter logic [29:0] SCHEDULE_PERIOD_NS = 30'd1000000,
  parameter logic [47:0] TIMESLOT_PERIOD_S  = 48'd0,
  parameter logic [29:0] TIMESLOT_PERIOD_NS = 30'd100000,
  parameter logic [47:0] ACTIVE_PERIOD_S    = 48'd0,
  parameter logic [29:0] ACTIVE_PERIOD_NS   = 30'd100000,
  parameter logic [29:0] GUARD_PERIOD_NS    = 30'd0,
  parameter int          SLOT_COUNT         = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [95:0]            input_ts_96,
  input  logic                   input_ts_step,
  input  logic                   enable,
  input  logic [79:0]            input_schedule_start,
  input  logic                   input_schedule_start_valid,
  input  logic [79:0]            input_schedule_period,
  input  logic                   input_schedule_period_valid,
  input  logic [79:0]            input_timeslot_period,
  input  logic                   input_timeslot_period_valid,
  input  logic [79:0]            input_active_period,
  input  logic                   input_active_period_valid,
  input  logic [29:0]            input_guard_period,
  input  logic                   input_guard_period_valid,
  input  logic [INDEX_WIDTH:0]   input_slot_count,
  input  logic                   input_slot_count_valid,
  input  logic                   tbl_wr_en,
  input  logic [INDEX_WIDTH-1:0] tbl_wr_addr,
  input  logic [CHANNELS-1:0]    tbl_wr_data,
  output logic                   locked,
  output logic                   error,
  output logic                   schedule_start,
  output logic [INDEX_WIDTH-1:0] timeslot_index,
  output logic                   timeslot_start,
  output logic                   timeslot_end,
  output logic                   timeslot_active,
  output logic [CHANNELS-1:0]    channel_active
);

  localparam logic [30:0] NS_PER_S = 31'd1_000_000_000;
  localparam logic [INDEX_WIDTH:0] SLOT_COUNT_INIT =
    (SLOT_COUNT == 0) ? (INDEX_WIDTH+1)'(1) : (INDEX_WIDTH+1)'(SLOT_COUNT);

  typedef enum logic [3:0] {
    IDLE, SCHED_1, SCHED_2, SLOT_1, SLOT_2, SLOT_3, SLOT_4, SLOT_5, SLOT_6
  } state_t;

  state_t state;

  logic [47:0] ts_s;
  logic [29:0] ts_ns;

  logic [47:0] sched_start_s, sched_period_s, slot_period_s, active_period_s;
  logic [29:0] sched_start_ns, sched_period_ns, slot_period_ns, active_period_ns;
  logic [29:0] guard_ns;
  logic [INDEX_WIDTH:0] slot_count;

  logic [47:0] next_sched_s, next_slot_s, guard_end_s, active_end_s;
  logic [29:0] next_sched_ns, next_slot_ns, guard_end_ns, active_end_ns;

  logic [47:0] add_a_s, add_b_s, sum_s, res_s;
  logic [29:0] add_a_ns, add_b_ns, sum_ns, res_ns;
  logic [30:0] sum_la;

  logic [CHANNELS-1:0] tbl [2**INDEX_WIDTH];
  logic [CHANNELS-1:0] tbl_rd, next_mask, cur_mask;
  logic [INDEX_WIDTH-1:0] rd_addr, nxt_index;
  logic [INDEX_WIDTH:0] idx_inc;

  logic [1:0] init_cnt;
  logic running, lock_arm;
  logic restart, sched_evt, slot_evt, guard_evt, active_evt;
  logic [47:0] new_start_s;
  logic [29:0] new_start_ns;

  logic unused_bits;
  assign unused_bits = ^{input_ts_96[47:46], input_ts_96[15:0],
                         input_schedule_start[31:30], input_schedule_period[31:30],
                         input_timeslot_period[31:30], input_active_period[31:30]};

  assign restart = input_schedule_start_valid | input_schedule_period_valid |
                   input_slot_count_valid | input_ts_step;

  assign new_start_s  = input_schedule_start_valid ? input_schedule_start[79:32] : sched_start_s;
  assign new_start_ns = input_schedule_start_valid ? input_schedule_start[29:0]  : sched_start_ns;

  assign idx_inc   = (INDEX_WIDTH+1)'(timeslot_index) + (INDEX_WIDTH+1)'(1);
  assign nxt_index = (idx_inc == slot_count) ? '0 : idx_inc[INDEX_WIDTH-1:0];

  // ns never reaches 1e9, so the concatenation compares as a single number
  assign sched_evt  = (init_cnt == 2'd0) && ({ts_s, ts_ns} > {next_sched_s, next_sched_ns});
  assign slot_evt   = running && ({ts_s, ts_ns} > {next_slot_s, next_slot_ns}) &&
                      (idx_inc < slot_count);
  assign guard_evt  = running && ({ts_s, ts_ns} > {guard_end_s, guard_end_ns});
  assign active_evt = running && ({ts_s, ts_ns} > {active_end_s, active_end_ns});

  // adder operand select; the sum registers load every cycle and the
  // following state picks whichever of sum / sum-1e9 is in range
  always_comb begin
    add_a_s  = next_slot_s;
    add_a_ns = next_slot_ns;
    add_b_s  = slot_period_s;
    add_b_ns = slot_period_ns;
    case (state)
      SCHED_1: begin
        add_a_s  = next_sched_s;
        add_a_ns = next_sched_ns;
        add_b_s  = sched_period_s;
        add_b_ns = sched_period_ns;
      end
      SLOT_1: begin
        add_b_s  = 48'd0;
        add_b_ns = guard_ns;
      end
      SLOT_3: begin
        add_b_s  = active_period_s;
        add_b_ns = active_period_ns;
      end
      default: ;
    endcase
  end

  // lookahead did not borrow: ns overflowed one second
  assign res_ns = sum_la[30] ? sum_ns : sum_la[29:0];
  assign res_s  = sum_la[30] ? sum_s  : sum_s + 48'd1;

  assign rd_addr = (state == SLOT_5) ? nxt_index : '0;

  // read-before-write: a same-address write returns the old bitmap
  always_ff @(posedge clk) begin
    if (tbl_wr_en) tbl[tbl_wr_addr] <= tbl_wr_data;
    tbl_rd <= tbl[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ts_s             <= '0;
      ts_ns            <= '0;
      sched_start_s    <= SCHEDULE_START_S;
      sched_start_ns   <= SCHEDULE_START_NS;
      sched_period_s   <= SCHEDULE_PERIOD_S;
      sched_period_ns  <= SCHEDULE_PERIOD_NS;
      slot_period_s    <= TIMESLOT_PERIOD_S;
      slot_period_ns   <= TIMESLOT_PERIOD_NS;
      active_period_s  <= ACTIVE_PERIOD_S;
      active_period_ns <= ACTIVE_PERIOD_NS;
      guard_ns         <= GUARD_PERIOD_NS;
      slot_count       <= SLOT_COUNT_INIT;
      next_sched_s     <= SCHEDULE_START_S;
      next_sched_ns    <= SCHEDULE_START_NS;
      next_slot_s      <= SCHEDULE_START_S;
      next_slot_ns     <= SCHEDULE_START_NS;
      guard_end_s      <= '0;
      guard_end_ns     <= '0;
      active_end_s     <= '0;
      active_end_ns    <= '0;
      sum_s            <= '0;
      sum_ns           <= '0;
      sum_la           <= '0;
      next_mask        <= '0;
      cur_mask         <= '0;
      init_cnt         <= 2'd2;
      running          <= 1'b0;
      lock_arm         <= 1'b0;
      locked           <= 1'b0;
      error            <= 1'b0;
      schedule_start   <= 1'b0;
      timeslot_index   <= '0;
      timeslot_start   <= 1'b0;
      timeslot_end     <= 1'b0;
      timeslot_active  <= 1'b0;
      channel_active   <= '0;
    end else begin
      ts_s   <= input_ts_96[95:48];
      ts_ns  <= input_ts_96[45:16];
      sum_s  <= add_a_s + add_b_s;
      sum_ns <= add_a_ns + add_b_ns;
      sum_la <= {1'b0, add_a_ns} + {1'b0, add_b_ns} - NS_PER_S;

      if (input_schedule_start_valid) begin
        sched_start_s  <= input_schedule_start[79:32];
        sched_start_ns <= input_schedule_start[29:0];
      end
      if (input_schedule_period_valid) begin
        sched_period_s  <= input_schedule_period[79:32];
        sched_period_ns <= input_schedule_period[29:0];
      end
      if (input_timeslot_period_valid) begin
        slot_period_s  <= input_timeslot_period[79:32];
        slot_period_ns <= input_timeslot_period[29:0];
      end
      if (input_active_period_valid) begin
        active_period_s  <= input_active_period[79:32];
        active_period_ns <= input_active_period[29:0];
      end
      if (input_guard_period_valid) guard_ns <= input_guard_period;
      if (input_slot_count_valid)
        slot_count <= (input_slot_count == '0) ? (INDEX_WIDTH+1)'(1) : input_slot_count;

      schedule_start <= 1'b0;
      timeslot_start <= 1'b0;
      timeslot_end   <= 1'b0;

      if (restart) begin
        state           <= IDLE;
        next_sched_s    <= new_start_s;
        next_sched_ns   <= new_start_ns;
        next_slot_s     <= new_start_s;
        next_slot_ns    <= new_start_ns;
        timeslot_index  <= '0;
        timeslot_end    <= timeslot_active;
        timeslot_active <= 1'b0;
        channel_active  <= '0;
        locked          <= 1'b0;
        lock_arm        <= 1'b0;
        running         <= 1'b0;
        error           <= input_ts_step;
        init_cnt        <= 2'd2;
      end else begin
        // table[0] is read over two cycles after a restart; the first
        // schedule event is held off until it has landed in next_mask
        if (init_cnt != 2'd0) begin
          init_cnt <= init_cnt - 2'd1;
          if (init_cnt == 2'd1) next_mask <= tbl_rd;
        end

        case (state)
          IDLE: begin
            if (sched_evt) begin
              timeslot_index  <= '0;
              locked          <= lock_arm;
              if (lock_arm) error <= 1'b0;
              schedule_start  <= enable & lock_arm;
              timeslot_start  <= enable & lock_arm;
              timeslot_end    <= timeslot_active;
              timeslot_active <= 1'b0;
              channel_active  <= '0;
              cur_mask        <= next_mask;
              running         <= 1'b1;
              state           <= SCHED_1;
            end else if (slot_evt) begin
              timeslot_index  <= idx_inc[INDEX_WIDTH-1:0];
              timeslot_start  <= enable & locked;
              timeslot_end    <= timeslot_active;
              timeslot_active <= 1'b0;
              channel_active  <= '0;
              cur_mask        <= next_mask;
              state           <= SLOT_1;
            end else begin
              // nothing to catch up on: safe to lock at the next schedule start
              if (running) lock_arm <= 1'b1;
              if (guard_evt && !active_evt) begin
                timeslot_active <= enable & locked;
                channel_active  <= cur_mask & {CHANNELS{enable & locked}};
              end else if (active_evt && timeslot_active) begin
                timeslot_active <= 1'b0;
                timeslot_end    <= 1'b1;
                channel_active  <= '0;
              end
            end
          end
          SCHED_1: begin
            next_slot_s  <= next_sched_s;
            next_slot_ns <= next_sched_ns;
            state        <= SCHED_2;
          end
          SCHED_2: begin
            next_sched_s  <= res_s;
            next_sched_ns <= res_ns;
            state         <= SLOT_1;
          end
          SLOT_1: state <= SLOT_2;
          SLOT_2: begin
            guard_end_s  <= res_s;
            guard_end_ns <= res_ns;
            state        <= SLOT_3;
          end
          SLOT_3: state <= SLOT_4;
          SLOT_4: begin
            active_end_s  <= res_s;
            active_end_ns <= res_ns;
            state         <= SLOT_5;
          end
          SLOT_5: state <= SLOT_6;
          SLOT_6: begin
            next_slot_s  <= res_s;
            next_slot_ns <= res_ns;
            next_mask    <= tbl_rd;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdma_scheduler_multi.sv
// tb_tdma_scheduler_multi
// Directed bench: ToD advances 1 us per clock, schedule 1 ms, slots 100 us,
// active 90 us, guard 1 us, 4 slots, bitmaps {1,2,4,8}. Outputs are sampled
// on the falling edge at hand-picked points well inside slot windows.
module tb_tdma_scheduler_multi;

  localparam int IW = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [95:0]   input_ts_96;
  logic          input_ts_step;
  logic          enable;
  logic [79:0]   input_schedule_start, input_schedule_period;
  logic [79:0]   input_timeslot_period, input_active_period;
  logic          input_schedule_start_valid, input_schedule_period_valid;
  logic          input_timeslot_period_valid, input_active_period_valid;
  logic [29:0]   input_guard_period;
  logic          input_guard_period_valid;
  logic [IW:0]   input_slot_count;
  logic          input_slot_count_valid;
  logic          tbl_wr_en;
  logic [IW-1:0] tbl_wr_addr;
  logic [CH-1:0] tbl_wr_data;
  logic          locked, error, schedule_start, timeslot_start, timeslot_end, timeslot_active;
  logic [IW-1:0] timeslot_index;
  logic [CH-1:0] channel_active;

  logic [47:0] tod_s;
  logic [29:0] tod_ns;
  assign input_ts_96 = {tod_s, 2'b00, tod_ns, 16'h0000};

  int n_checks = 0;
  int n_errors = 0;
  int n_sched, n_tstart, n_tend;

  always #5 clk = ~clk;

  tdma_scheduler_multi #(
    .INDEX_WIDTH(IW), .CHANNELS(CH),
    .SCHEDULE_START_S(48'd1), .SCHEDULE_START_NS(30'd0),
    .SCHEDULE_PERIOD_S(48'd0), .SCHEDULE_PERIOD_NS(30'd1_000_000),
    .TIMESLOT_PERIOD_S(48'd0), .TIMESLOT_PERIOD_NS(30'd100_000),
    .ACTIVE_PERIOD_S(48'd0), .ACTIVE_PERIOD_NS(30'd90_000),
    .GUARD_PERIOD_NS(30'd1000), .SLOT_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .input_ts_96(input_ts_96), .input_ts_step(input_ts_step), .enable(enable),
    .input_schedule_start(input_schedule_start),
    .input_schedule_start_valid(input_schedule_start_valid),
    .input_schedule_period(input_schedule_period),
    .input_schedule_period_valid(input_schedule_period_valid),
    .input_timeslot_period(input_timeslot_period),
    .input_timeslot_period_valid(input_timeslot_period_valid),
    .input_active_period(input_active_period),
    .input_active_period_valid(input_active_period_valid),
    .input_guard_period(input_guard_period),
    .input_guard_period_valid(input_guard_period_valid),
    .input_slot_count(input_slot_count),
    .input_slot_count_valid(input_slot_count_valid),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .locked(locked), .error(error), .schedule_start(schedule_start),
    .timeslot_index(timeslot_index), .timeslot_start(timeslot_start),
    .timeslot_end(timeslot_end), .timeslot_active(timeslot_active),
    .channel_active(channel_active)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: sample pulses on the falling edge, then advance ToD by 1 us
  task automatic tick();
    @(negedge clk);
    if (schedule_start) n_sched++;
    if (timeslot_start) n_tstart++;
    if (timeslot_end)   n_tend++;
    if (tod_ns >= 30'd999_999_000) begin
      tod_ns = tod_ns - 30'd999_999_000;
      tod_s  = tod_s + 48'd1;
    end else begin
      tod_ns = tod_ns + 30'd1000;
    end
  endtask

  task automatic run_to(input logic [47:0] s, input logic [29:0] ns);
    int cnt;
    cnt = 0;
    while (({tod_s, tod_ns} < {s, ns}) && (cnt < 20000)) begin
      tick();
      cnt++;
    end
    chk("run_to_reached", 96'({tod_s, tod_ns} >= {s, ns}), 96'd1);
  endtask

  task automatic tbl_write(input logic [IW-1:0] a, input logic [CH-1:0] d);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = a;
    tbl_wr_data = d;
    tick();
    tbl_wr_en   = 1'b0;
  endtask

  task automatic clear_counts();
    n_sched  = 0;
    n_tstart = 0;
    n_tend   = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    input_ts_step = 1'b0;
    enable = 1'b1;
    input_schedule_start = '0;  input_schedule_start_valid = 1'b0;
    input_schedule_period = '0; input_schedule_period_valid = 1'b0;
    input_timeslot_period = '0; input_timeslot_period_valid = 1'b0;
    input_active_period = '0;   input_active_period_valid = 1'b0;
    input_guard_period = '0;    input_guard_period_valid = 1'b0;
    input_slot_count = '0;      input_slot_count_valid = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    tod_s = '0; tod_ns = '0;
    clear_counts();

    repeat (2) tick();
    tbl_write(8'd0, 4'h1);
    tbl_write(8'd1, 4'h2);
    tbl_write(8'd2, 4'h4);
    tbl_write(8'd3, 4'h8);

    chk("reset_status", {locked, error}, 0);
    chk("reset_pulses", {schedule_start, timeslot_start, timeslot_end}, 0);
    chk("reset_active", {timeslot_active, channel_active}, 0);
    chk("reset_index", timeslot_index, 0);

    // test 1: first period runs unlocked, second locks
    tod_s = 48'd0; tod_ns = 30'd999_000_000;
    rst = 1'b0;
    clear_counts();
    run_to(48'd1, 30'd50_000);
    chk("t1_idx0", timeslot_index, 0);
    chk("t1_unlocked", locked, 0);
    run_to(48'd1, 30'd150_000);
    chk("t1_idx1", timeslot_index, 1);
    run_to(48'd1, 30'd250_000);
    chk("t1_idx2", timeslot_index, 2);
    run_to(48'd1, 30'd350_000);
    chk("t1_idx3", timeslot_index, 3);
    run_to(48'd1, 30'd950_000);
    chk("t1_idx_hold", timeslot_index, 3);
    chk("t1_no_pulses_unlocked", n_tstart + n_sched, 0);
    chk("t1_no_activity_unlocked", n_tend, 0);
    run_to(48'd1, 30'd1_050_000);
    chk("t1_locked", locked, 1);
    chk("t1_idx0_p2", timeslot_index, 0);
    chk("t1_sched_pulse", n_sched, 1);
    chk("t1_start_pulse", n_tstart, 1);

    // test 2: channel gating in the locked period
    chk("t2_active_s0", timeslot_active, 1);
    chk("t2_chan_s0", channel_active, 4'h1);
    clear_counts();
    run_to(48'd1, 30'd1_095_000);
    chk("t2_inactive_after_end", {timeslot_active, channel_active}, 0);
    chk("t2_end_pulse", n_tend, 1);
    run_to(48'd1, 30'd1_150_000);
    chk("t2_idx1", timeslot_index, 1);
    chk("t2_chan_s1", channel_active, 4'h2);
    chk("t2_start_s1", n_tstart, 1);

    // test 5: table rewrites during slot 0 of the third period
    run_to(48'd1, 30'd2_050_000);
    tbl_write(8'd1, 4'h3);
    tbl_write(8'd2, 4'hF);
    run_to(48'd1, 30'd2_150_000);
    chk("t5_old_bitmap_s1", channel_active, 4'h2);
    run_to(48'd1, 30'd2_250_000);
    chk("t5_new_bitmap_s2", channel_active, 4'hF);
    run_to(48'd1, 30'd3_150_000);
    chk("t5_new_bitmap_s1_next", channel_active, 4'h3);

    // test 3: time step mid-slot
    input_ts_step = 1'b1;
    tick();
    input_ts_step = 1'b0;
    chk("t3_error", error, 1);
    chk("t3_unlocked", locked, 0);
    chk("t3_drop_active", {timeslot_active, channel_active}, 0);
    chk("t3_end_pulse", timeslot_end, 1);
    run_to(48'd1, 30'd3_500_000);
    chk("t3_error_held", {error, locked}, 2'b10);
    run_to(48'd1, 30'd4_050_000);
    chk("t3_relocked", {error, locked}, 2'b01);
    chk("t3_idx0", timeslot_index, 0);

    // test 4: start written with ns near rollover, slot count 2
    tod_s = 48'd5; tod_ns = 30'd999_900_000;
    input_schedule_start = {48'd5, 2'b00, 30'd999_950_000};
    input_schedule_start_valid = 1'b1;
    input_slot_count = 9'd2;
    input_slot_count_valid = 1'b1;
    tick();
    input_schedule_start_valid = 1'b0;
    input_slot_count_valid = 1'b0;
    clear_counts();
    run_to(48'd6, 30'd0);
    chk("t4_idx0", timeslot_index, 0);
    run_to(48'd6, 30'd100_000);
    chk("t4_idx1_after_carry", timeslot_index, 1);
    run_to(48'd6, 30'd200_000);
    chk("t4_count_suppress", timeslot_index, 1);
    run_to(48'd6, 30'd990_000);
    chk("t4_sched_carry", {locked, timeslot_index}, {1'b1, 8'd0});
    chk("t4_sched_pulse", n_sched, 1);

    // test 6: asynchronous reset while active
    run_to(48'd6, 30'd1_000_000);
    chk("t6_active_before", {timeslot_active, channel_active}, {1'b1, 4'h1});
    #2 rst = 1'b1;
    #1;
    chk("t6_async_active", {timeslot_active, channel_active}, 0);
    chk("t6_async_status", {locked, error, timeslot_index}, 0);
    tod_s = 48'd0; tod_ns = 30'd999_500_000;
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    run_to(48'd1, 30'd350_000);
    chk("t6_param_count", timeslot_index, 3);
    run_to(48'd1, 30'd1_050_000);
    chk("t6_relocked", {locked, timeslot_index}, {1'b1, 8'd0});

    // enable low: index advances, no pulses or activity, lock kept
    enable = 1'b0;
    clear_counts();
    run_to(48'd1, 30'd1_150_000);
    chk("en_idx1", timeslot_index, 1);
    chk("en_no_activity", {timeslot_active, channel_active}, 0);
    chk("en_no_start", n_tstart, 0);
    chk("en_locked", locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
